// File: rtl/ysyx_040750_imem_resp.sv
// Instruction-fetch responder: one outstanding fetch, 64-bit memory read, 32-bit half select.
// Define YSYX_040750_IBUF_EN to add a one-entry line buffer that serves repeat fetches without memory access.
//
// state | meaning
// IDLE  | no request in flight, ready to accept
// REQ   | memory read request asserted, waiting for grant
// WAIT  | granted, waiting for read data
// RESP  | O_inst_valid pulse; may accept the next request
module ysyx_040750_imem_resp #(
   parameter logic [31:0] ERR_INST  = 32'h00100073,
   parameter int unsigned BUF_TAG_W = 29
) (
   input  logic        I_sys_clk,
   input  logic        I_rst,
   input  logic        I_pc_valid,
   input  logic [31:0] I_addr,
   input  logic        I_fencei,
   output logic        O_inst_ready,
   output logic        O_inst_valid,
   output logic [31:0] O_inst,
   output logic        O_mem_req,
   output logic [31:0] O_mem_addr,
   input  logic        I_mem_gnt,
   input  logic        I_mem_rvalid,
   input  logic [63:0] I_mem_rdata,
   input  logic        I_mem_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:2] addr_q, addr_d;
   logic [31:0] inst_q, inst_d;

   logic        accept;
   logic        misalign;
   logic        buf_hit;
   logic [31:0] buf_inst;
   logic        fill;
   logic [31:0] rd_sel;

   assign O_inst_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign O_inst_valid = (state_q == ST_RESP);
   assign O_mem_req    = (state_q == ST_REQ);
   assign O_mem_addr   = {addr_q[31:32-BUF_TAG_W], {(32-BUF_TAG_W){1'b0}}};
   assign O_inst       = inst_q;

   assign accept   = I_pc_valid && O_inst_ready && !I_fencei;
   assign misalign = (I_addr[1:0] != 2'b00);
   assign rd_sel   = addr_q[2] ? I_mem_rdata[63:32] : I_mem_rdata[31:0];

   // Read data counts only while a read is actually outstanding; stray rvalid elsewhere is dropped.
   assign fill = I_mem_rvalid &&
                 (((state_q == ST_REQ) && I_mem_gnt) || (state_q == ST_WAIT));

`ifdef YSYX_040750_IBUF_EN
   logic                 buf_vld_q, buf_vld_d;
   logic [BUF_TAG_W-1:0] buf_tag_q, buf_tag_d;
   logic [63:0]          buf_data_q, buf_data_d;
   logic                 taint_q, taint_d;

   assign buf_hit  = buf_vld_q && (buf_tag_q == I_addr[31:32-BUF_TAG_W]);
   assign buf_inst = I_addr[2] ? buf_data_q[63:32] : buf_data_q[31:0];

   // taint marks a read that overlapped a fence.i; its data may be stale and must not be cached.
   always_comb begin
      buf_vld_d  = buf_vld_q;
      buf_tag_d  = buf_tag_q;
      buf_data_d = buf_data_q;
      taint_d    = taint_q;
      if (accept) begin
         taint_d = 1'b0;
      end else if (I_fencei && ((state_q == ST_REQ) || (state_q == ST_WAIT))) begin
         taint_d = 1'b1;
      end
      if (fill && !I_mem_err && !taint_q) begin
         buf_vld_d  = 1'b1;
         buf_tag_d  = addr_q[31:32-BUF_TAG_W];
         buf_data_d = I_mem_rdata;
      end
      if (fill && I_mem_err) begin
         buf_vld_d = 1'b0;
      end
      if (I_fencei) begin
         buf_vld_d = 1'b0;
      end
   end

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         buf_vld_q  <= 1'b0;
         buf_tag_q  <= '0;
         buf_data_q <= '0;
         taint_q    <= 1'b0;
      end else begin
         buf_vld_q  <= buf_vld_d;
         buf_tag_q  <= buf_tag_d;
         buf_data_q <= buf_data_d;
         taint_q    <= taint_d;
      end
   end
`else
   assign buf_hit  = 1'b0;
   assign buf_inst = 32'h0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               addr_d  = I_addr[31:2];
               state_d = (misalign || buf_hit) ? ST_RESP : ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (I_mem_gnt) begin
               state_d = I_mem_rvalid ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (I_mem_rvalid) begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      inst_d = inst_q;
      if (fill) begin
         inst_d = I_mem_err ? ERR_INST : rd_sel;
      end else if (accept && misalign) begin
         inst_d = ERR_INST;
      end else if (accept && buf_hit) begin
         inst_d = buf_inst;
      end
   end

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         inst_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
      end
   end

endmodule

// File: tb/tb_ysyx_040750_imem_resp.sv
// Scoreboard bench for ysyx_040750_imem_resp: directed handshake cases plus randomized fetches
// against a memory whose contents and error lines are a pure function of address.
module tb_ysyx_040750_imem_resp;

   localparam logic [31:0] ERR = 32'h00100073;

   logic        clk = 1'b0;
   logic        rst, pc_valid, fencei;
   logic [31:0] addr;
   logic        inst_ready, inst_valid, mem_req;
   logic [31:0] inst, mem_addr;
   logic        mem_gnt, mem_rvalid, mem_err;
   logic [63:0] mem_rdata;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb[$];
   int          gnt_dly  = 0;
   int          rv_dly   = 0;
   bit          rand_mem = 1'b0;
   int          req_seen = 0;

   always #5 clk = ~clk;

   ysyx_040750_imem_resp dut (
      .I_sys_clk    (clk),
      .I_rst        (rst),
      .I_pc_valid   (pc_valid),
      .I_addr       (addr),
      .I_fencei     (fencei),
      .O_inst_ready (inst_ready),
      .O_inst_valid (inst_valid),
      .O_inst       (inst),
      .O_mem_req    (mem_req),
      .O_mem_addr   (mem_addr),
      .I_mem_gnt    (mem_gnt),
      .I_mem_rvalid (mem_rvalid),
      .I_mem_rdata  (mem_rdata),
      .I_mem_err    (mem_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      logic [31:0] l;
      l = {a[31:3], 3'b000};
      if (l == 32'h80000000) return 64'h11223344_AABBCCDD;
      return {l ^ 32'h9E3779B9, (l * 32'd2654435761) ^ 32'h7F4A7C15};
   endfunction

   function automatic logic err_line(input logic [31:0] a);
      return a[8:3] == 6'h2A;
   endfunction

   function automatic logic [31:0] ref_inst(input logic [31:0] a);
      logic [63:0] w;
      if (a[1:0] != 2'b00) return ERR;
      if (err_line(a)) return ERR;
      w = mem_word(a);
      return a[2] ? w[63:32] : w[31:0];
   endfunction

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic fetch(input logic [31:0] a);
      int n;
      n = 0;
      pc_valid = 1'b1;
      addr     = a;
      while (!(inst_ready && !fencei) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk("accept_timeout", 64'(n), 64'd0);
      end else begin
         sb.push_back(ref_inst(a));
         @(posedge clk);
         @(negedge clk);
      end
      pc_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (!inst_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(nm, inst_valid, 1'b1);
   endtask

   // Memory model: grant and data delays set by the stimulus or randomized.
   initial begin
      logic [31:0] ma;
      int gd, rd;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
         if (mem_req && !rst) begin
            ma = mem_addr;
            req_seen++;
            chk("maddr_align", 64'(ma[2:0]), 64'd0);
            gd = rand_mem ? int'($urandom_range(0, 3)) : gnt_dly;
            rd = rand_mem ? int'($urandom_range(0, 3)) : rv_dly;
            for (int i = 0; i < gd; i++) begin
               @(negedge clk);
               chk("req_hold", mem_req, 1'b1);
               chk("addr_hold", mem_addr, ma);
            end
            mem_gnt = 1'b1;
            if (rd > 0) begin
               @(negedge clk);
               mem_gnt = 1'b0;
               for (int i = 1; i < rd; i++) @(negedge clk);
            end
            mem_rvalid = 1'b1;
            mem_err    = err_line(ma);
            mem_rdata  = mem_word(ma);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && inst_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got inst %0h, want no response", inst);
         end else begin
            chk("inst", inst, sb.pop_front());
         end
      end
   end

   initial begin
      int n, reqc, rq;
      logic [31:0] a;
      rst = 1'b1; pc_valid = 1'b0; fencei = 1'b0; addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_maddr", mem_addr, 32'h0);
      chk("rst_ready", inst_ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // earliest-latency read, upper half
      gnt_dly = 0; rv_dly = 0;
      fetch(32'h80000004);
      chk("t1_req", mem_req, 1'b1);
      chk("t1_maddr", mem_addr, 32'h80000000);
      @(negedge clk);
      chk("t1_valid", inst_valid, 1'b1);
      chk("t1_inst", inst, 32'h11223344);

      // accepted during RESP, delayed grant and data
      gnt_dly = 3; rv_dly = 2;
      fetch(32'h80000000);
      n = 0; reqc = 0;
      while (!inst_valid && n < 30) begin
         if (mem_req) reqc++;
         chk("t2_ready_low", inst_ready, 1'b0);
         @(negedge clk);
         n++;
      end
      chk("t2_valid", inst_valid, 1'b1);
      chk("t2_req_cycles", 64'(reqc), 64'd4);
      chk("t2_inst", inst, 32'hAABBCCDD);
      @(negedge clk);
      chk("t2_single_pulse", inst_valid, 1'b0);

      // misaligned: no memory access, response next cycle
      gnt_dly = 0; rv_dly = 0;
      rq = req_seen;
      fetch(32'h80000002);
      chk("t3_valid", inst_valid, 1'b1);
      chk("t3_noreq", mem_req, 1'b0);
      chk("t3_inst", inst, ERR);
      @(negedge clk);
      chk("t3_req_count", 64'(req_seen), 64'(rq));

      // memory error
      fetch(32'h80000150);
      @(negedge clk);
      chk("t3e_valid", inst_valid, 1'b1);
      chk("t3e_inst", inst, ERR);
      @(negedge clk);

      // fence.i blocks accepts
      fencei = 1'b1; pc_valid = 1'b1; addr = 32'h80000010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_fence_noreq", mem_req, 1'b0);
         chk("t4_fence_novalid", inst_valid, 1'b0);
      end
      fencei = 1'b0; pc_valid = 1'b0;
      @(negedge clk);

      // reset while waiting for data, stray rvalid afterwards
      gnt_dly = 0; rv_dly = 4;
      fetch(32'h80000008);
      @(negedge clk);
      chk("t5_in_wait", inst_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      chk("t5_inst_cleared", inst, 32'h0);
      for (int i = 0; i < 6; i++) begin
         chk("t5_novalid", inst_valid, 1'b0);
         chk("t5_idle", inst_ready, 1'b1);
         @(negedge clk);
      end

`ifdef YSYX_040750_IBUF_EN
      gnt_dly = 0; rv_dly = 1;
      fetch(32'h80000000);
      wait_valid("b1_first_valid");
      rq = req_seen;
      fetch(32'h80000004);
      chk("b1_hit_valid", inst_valid, 1'b1);
      chk("b1_hit_noreq", mem_req, 1'b0);
      chk("b1_hit_inst", inst, 32'h11223344);
      @(negedge clk);
      chk("b1_hit_req_count", 64'(req_seen), 64'(rq));
      fencei = 1'b1;
      @(negedge clk);
      fencei = 1'b0;
      fetch(32'h80000004);
      chk("b2_miss_req", mem_req, 1'b1);
      wait_valid("b2_valid");
      @(negedge clk);
`endif

      // randomized traffic
      rand_mem = 1'b1;
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0: begin
               fencei = 1'b1; pc_valid = 1'b1; addr = $urandom;
               repeat ($urandom_range(1, 2)) @(negedge clk);
               fencei = 1'b0; pc_valid = 1'b0;
            end
            1: @(negedge clk);
            default: ;
         endcase
         a = 32'h80000000 | ($urandom_range(0, 63) << 3) | ($urandom_range(0, 1) << 2);
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         fetch(a);
         if ($urandom_range(0, 7) == 0) begin
            fencei = 1'b1;
            @(negedge clk);
            fencei = 1'b0;
         end
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
